music_control: RTL

//   Control FSM directly upstream of datapath. Turns raw user buttons into the

---
 rtl/music_control.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/music_control.sv
`default_nettype none
// ============================================================================
// Module   : music_control
// Purpose  : Control FSM ahead of the note datapath. Converts raw user buttons
//            into load/play strobes, records up to 16 notes and steps
//            note_counter through them at a fixed tempo during playback.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            add_note_btn        - rising edge stores the current note
//            play_btn            - rising edge starts playback
//            stop_btn            - rising edge aborts playback
//            loop_en             - 1: wrap after last note, 0: stop
//            ld_note             - 1-cycle pulse, datapath writes next slot
//            display_note        - 1-cycle pulse, cycle after ld_note
//            ld_play / playing   - high for the whole of playback
//            next_note_en        - 1-cycle pulse at start of each played note
//            note_counter [3:0]  - slot being played
//            notes_stored [4:0]  - number of stored notes, 0..16
// Revision : 1.0 - initial release
// ============================================================================
module music_control #(
  parameter int NOTE_TICKS = 25_000_000,
  parameter int TICK_W     = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_note_btn,
  input  logic       play_btn,
  input  logic       stop_btn,
  input  logic       loop_en,
  output logic       ld_note,
  output logic       display_note,
  output logic       ld_play,
  output logic       next_note_en,
  output logic [3:0] note_counter,
  output logic [4:0] notes_stored,
  output logic       playing
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_GAP    = 3'd2,
    S_PLAY_START = 3'd3,
    S_PLAY_HOLD  = 3'd4
  } state_t;

  // PLAY_START itself is one cycle of the note, so the hold phase counts
  // NOTE_TICKS-2 down to 0 to give exactly NOTE_TICKS cycles per note.
  localparam logic [TICK_W-1:0] C_TICK_RELOAD = TICK_W'(NOTE_TICKS - 2);
  localparam logic [TICK_W-1:0] C_TICK_ONE    = TICK_W'(1);
  localparam logic [4:0]        C_MAX_NOTES   = 5'd16;

  state_t            r_state, w_state_next;
  logic              r_add_q, r_play_q, r_stop_q;
  logic [TICK_W-1:0] r_tick, w_tick_next;
  logic [3:0]        r_note_cnt, w_note_cnt_next;
  logic [4:0]        r_stored, w_stored_next;

  logic w_add_edge, w_play_edge, w_stop_edge, w_last_note;

  assign w_add_edge  = add_note_btn & ~r_add_q;
  assign w_play_edge = play_btn     & ~r_play_q;
  assign w_stop_edge = stop_btn     & ~r_stop_q;
  assign w_last_note = ({1'b0, r_note_cnt} + 5'd1) >= r_stored;

  always_ff @(posedge clk) begin
    // The edge registers always follow the button level, including during
    // reset, so a button held through reset is seen as already pressed.
    r_add_q  <= add_note_btn;
    r_play_q <= play_btn;
    r_stop_q <= stop_btn;
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_note_cnt <= '0;
      r_stored   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tick     <= w_tick_next;
      r_note_cnt <= w_note_cnt_next;
      r_stored   <= w_stored_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_next     = r_tick;
    w_note_cnt_next = r_note_cnt;
    w_stored_next   = r_stored;
    case (r_state)
      S_IDLE: begin
        // An add edge always beats a simultaneous play edge; at 16 notes it
        // is dropped so the datapath slot pointer never wraps.
        if (w_add_edge) begin
          if (r_stored < C_MAX_NOTES) w_state_next = S_REC;
        end else if (w_play_edge && (r_stored != 5'd0)) begin
          w_state_next    = S_PLAY_START;
          w_note_cnt_next = 4'd0;
        end
      end
      S_REC: begin
        if (r_stored < C_MAX_NOTES) w_stored_next = r_stored + 5'd1;
        w_state_next = S_REC_GAP;
      end
      S_REC_GAP: begin
        w_state_next = S_IDLE;
      end
      S_PLAY_START: begin
        w_tick_next = C_TICK_RELOAD;
        if (w_stop_edge) w_state_next = S_IDLE;
        else             w_state_next = S_PLAY_HOLD;
      end
      S_PLAY_HOLD: begin
        if (w_stop_edge) begin
          w_state_next = S_IDLE;
        end else if (r_tick == '0) begin
          if (!w_last_note) begin
            w_note_cnt_next = r_note_cnt + 4'd1;
            w_state_next    = S_PLAY_START;
          end else if (loop_en) begin
            w_note_cnt_next = 4'd0;
            w_state_next    = S_PLAY_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_tick_next = r_tick - C_TICK_ONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // All outputs decode registered state only.
  assign ld_note      = (r_state == S_REC);
  assign display_note = (r_state == S_REC_GAP);
  assign ld_play      = (r_state == S_PLAY_START) || (r_state == S_PLAY_HOLD);
  assign next_note_en = (r_state == S_PLAY_START);
  assign playing      = ld_play;
  assign note_counter = r_note_cnt;
  assign notes_stored = r_stored;

endmodule
`default_nettype wire
